// File: rtl/tinycpu_outport_if.sv
// Bus between the tinycpu OUT port, the output FIFO and the host consumer.
// The master side drives the CPU write strobe and host ready; the FIFO is the slave.
interface tinycpu_outport_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
);
   logic [WIDTH-1:0] out_data;
   logic             out_we;
   logic             stall;
   logic [WIDTH-1:0] host_data;
   logic             host_valid;
   logic             host_ready;
   logic [AW:0]      level;
   logic             ovf;
   logic [7:0]       drop_cnt;
   logic             clr_ovf;

   modport master (
      output out_data, out_we, host_ready, clr_ovf,
      input  stall, host_data, host_valid, level, ovf, drop_cnt
   );

   modport slave (
      input  out_data, out_we, host_ready, clr_ovf,
      output stall, host_data, host_valid, level, ovf, drop_cnt
   );
endinterface

// File: rtl/tinycpu_outport.sv
// Show-ahead FIFO capturing tinycpu OUT writes and draining them to a host over valid/ready.
// Stalls the CPU when full and counts writes lost while full (sticky flag + saturating counter).
module tinycpu_outport #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic                clk,
   input  logic                reset,
   tinycpu_outport_if.slave    bus
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             r_ovf;
   logic [7:0]       r_drop_cnt;

   logic w_full;
   logic w_nonempty;
   logic w_pop;
   logic w_push;
   logic w_drop;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_full     = (r_level == LVL_FULL);
   assign w_nonempty = (r_level != '0);
   assign w_pop      = w_nonempty & bus.host_ready;
   // A write while full is still accepted when the head leaves in the same cycle.
   assign w_push     = bus.out_we & (~w_full | w_pop);
   assign w_drop     = bus.out_we & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.out_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // A drop in the same cycle as a clear wins, restarting the count at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_ovf      <= 1'b1;
         r_drop_cnt <= bus.clr_ovf ? 8'd1 : sat_inc8(r_drop_cnt);
      end else if (bus.clr_ovf) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

   assign bus.stall      = w_full;
   assign bus.host_valid = w_nonempty;
   assign bus.host_data  = w_nonempty ? r_mem[r_rd_ptr] : '0;
   assign bus.level      = r_level;
   assign bus.ovf        = r_ovf;
   assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_tinycpu_outport.sv
// Directed bench for tinycpu_outport: vector table for pass-through/fill/overflow/full push-pop,
// plus hand sequences for pointer wrap, counter saturation and asynchronous reset.
module tb_tinycpu_outport;

   logic clk;
   logic reset;

   tinycpu_outport_if #(.WIDTH(16), .AW(3)) bus ();

   tinycpu_outport #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] d;
      logic        rdy;
      logic        clr;
      logic [3:0]  lvl;
      logic [15:0] hd;
      logic        ov;
      logic [7:0]  dc;
   } vec_t;

   vec_t vq[$];
   int   checks;
   int   errors;
   logic [15:0] model[$];

   task automatic add(input int we, input int d, input int rdy, input int clr,
                      input int lvl, input int hd, input int ov, input int dc);
      vec_t v;
      v.we  = 1'(we);
      v.d   = 16'(d);
      v.rdy = 1'(rdy);
      v.clr = 1'(clr);
      v.lvl = 4'(lvl);
      v.hd  = 16'(hd);
      v.ov  = 1'(ov);
      v.dc  = 8'(dc);
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int lvl, input int hd, input int ov, input int dc);
      chk({tag, ".level"},      32'(bus.level),      32'(lvl));
      chk({tag, ".host_valid"}, 32'(bus.host_valid), 32'(lvl != 0));
      chk({tag, ".stall"},      32'(bus.stall),      32'(lvl == 8));
      chk({tag, ".host_data"},  32'(bus.host_data),  32'(hd));
      chk({tag, ".ovf"},        32'(bus.ovf),        32'(ov));
      chk({tag, ".drop_cnt"},   32'(bus.drop_cnt),   32'(dc));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input int we, input int d, input int rdy, input int clr);
      bus.out_we     = 1'(we);
      bus.out_data   = 16'(d);
      bus.host_ready = 1'(rdy);
      bus.clr_ovf    = 1'(clr);
      step();
      bus.out_we  = 1'b0;
      bus.clr_ovf = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset          = 1'b0;
      bus.out_we     = 1'b0;
      bus.out_data   = '0;
      bus.host_ready = 1'b0;
      bus.clr_ovf    = 1'b0;

      // pass-through
      add(1, 16'h0002, 1, 0, 1, 16'h0002, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 16'h0005, 1, 0, 1, 16'h0005, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);
      // fill to full with host stalled
      for (int i = 1; i <= 8; i++) add(1, i, 0, 0, i, 1, 0, 0);
      // overflow drops, clear, clear-with-drop, clear
      for (int k = 1; k <= 3; k++) add(1, 8 + k, 0, 0, 8, 1, 1, k);
      add(0, 0, 0, 1, 8, 1, 0, 0);
      add(1, 16'h0077, 0, 1, 8, 1, 1, 1);
      add(0, 0, 0, 1, 8, 1, 0, 0);
      // drain: only 1..8 come out
      for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 8 - i, (i < 8) ? i + 1 : 0, 0, 0);
      // full with simultaneous push and pop
      for (int i = 1; i <= 8; i++) add(1, i, 0, 0, i, 1, 0, 0);
      add(1, 16'h00AA, 1, 0, 8, 2, 0, 0);
      for (int i = 3; i <= 8; i++) add(0, 0, 1, 0, 10 - i, i, 0, 0);
      add(0, 0, 1, 0, 1, 16'h00AA, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0);

      // reset held, then idle
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("rst%0d", i), 0, 0, 0, 0);
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_all($sformatf("idle%0d", i), 0, 0, 0, 0);
      end

      foreach (vq[i]) begin
         cyc(vq[i].we, vq[i].d, vq[i].rdy, vq[i].clr);
         chk_all($sformatf("vec%0d", i), vq[i].lvl, vq[i].hd, vq[i].ov, vq[i].dc);
      end

      // sustained push+pop at full, well past one pointer lap
      model.delete();
      for (int i = 0; i < 8; i++) begin
         cyc(1, 16'h0010 + i, 0, 0);
         model.push_back(16'h0010 + 16'(i));
      end
      for (int j = 0; j < 11; j++) begin
         cyc(1, 16'h0020 + j, 1, 0);
         void'(model.pop_front());
         model.push_back(16'h0020 + 16'(j));
         chk_all($sformatf("wrap%0d", j), 8, model[0], 0, 0);
      end
      for (int j = 0; j < 8; j++) begin
         cyc(0, 0, 1, 0);
         void'(model.pop_front());
         chk_all($sformatf("wdrain%0d", j), 7 - j, (model.size() != 0) ? model[0] : 0, 0, 0);
      end

      // drop counter saturates at 255
      for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
      for (int k = 0; k < 254; k++) cyc(1, 16'hDEAD, 0, 0);
      chk_all("sat254", 8, 1, 1, 254);
      cyc(1, 16'hDEAD, 0, 0);
      chk_all("sat255", 8, 1, 1, 255);
      cyc(1, 16'hDEAD, 0, 0);
      chk_all("sat_hold", 8, 1, 1, 255);
      cyc(0, 0, 0, 1);
      chk_all("sat_clr", 8, 1, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0);
         chk_all($sformatf("sdrain%0d", i), 8 - i, (i < 8) ? i + 1 : 0, 0, 0);
      end

      // asynchronous reset between edges
      for (int i = 1; i <= 5; i++) cyc(1, 16'h0040 + i, 0, 0);
      chk_all("pre_arst", 5, 16'h0041, 0, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk_all("arst_now", 0, 0, 0, 0);
      step();
      step();
      chk_all("arst_hold", 0, 0, 0, 0);
      reset = 1'b1;
      step();
      cyc(1, 16'h1234, 0, 0);
      chk_all("post_arst", 1, 16'h1234, 0, 0);
      cyc(0, 0, 1, 0);
      chk_all("post_arst_pop", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
